riscv_mem_arbiter: RTL and testbench



---
 rtl/riscv_mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_mem_arbiter
//
// Purpose:
//   Shares one single-port synchronous memory between the RV32I core's
//   instruction-fetch requester and its load/store requester. Requests are
//   arbitrated round-robin. Each access holds the memory port for WAIT+1
//   cycles. The winner then receives a one-cycle acknowledge together with
//   registered read data.
//
// Parameters:
//   WAIT  extra memory cycles per access (0..15)
//   CW    width of the wait counter
//
// Ports:
//   clk      system clock
//   clrn     synchronous active-low reset
//   i_req    fetch request, held until i_ack
//   i_addr   fetch address
//   i_ack    one-cycle fetch completion pulse
//   i_inst   fetched instruction, held until the next completed fetch
//   d_req    data request, held until d_ack
//   d_addr   load/store address
//   d_we     byte write enables (0 = load)
//   d_wdata  store data
//   d_ack    one-cycle data completion pulse
//   d_rdata  load data, held until the next completed load
//   m_addr   memory address (held in IDLE)
//   m_wdata  memory write data (held in IDLE)
//   m_write  memory byte write enables
//   m_read   memory read strobe
//   m_rdata  memory read data, valid on the last access cycle
//   busy     high while an access or its acknowledge is in progress
//   owner    current or last grantee (0 = fetch, 1 = data)
// ---------------------------------------------------------------------------
module riscv_mem_arbiter #(
  parameter int WAIT = 1,
  parameter int CW   = 4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_inst,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_write,
  output logic        m_read,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  localparam logic [CW-1:0] WAIT_CNT  = CW'(WAIT);
  localparam logic          OWN_FETCH = 1'b0;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_m_addr;
  logic [31:0]   r_m_wdata;
  logic [3:0]    r_m_write;
  logic          r_m_read;
  logic          r_i_ack;
  logic          r_d_ack;
  logic [31:0]   r_i_inst;
  logic [31:0]   r_d_rdata;
  logic          r_owner;
  logic          r_busy;

  logic          w_any_req;
  logic          w_grant_data;

  assign w_any_req = i_req | d_req;

  // Data wins when it is the only requester, or on a tie when fetch was the
  // last grantee. Because owner resets to data, fetch wins the first tie.
  assign w_grant_data = d_req & (~i_req | (r_owner == OWN_FETCH));

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_m_addr  <= 32'd0;
      r_m_wdata <= 32'd0;
      r_m_write <= 4'd0;
      r_m_read  <= 1'b0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_i_inst  <= 32'd0;
      r_d_rdata <= 32'd0;
      r_owner   <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_i_ack <= 1'b0;
          r_d_ack <= 1'b0;
          if (w_any_req) begin
            // Requester inputs are latched here once. Later changes on
            // them do not affect this access.
            r_state <= ST_ACCESS;
            r_busy  <= 1'b1;
            r_cnt   <= WAIT_CNT;
            r_owner <= w_grant_data;
            if (w_grant_data) begin
              r_m_addr  <= d_addr;
              r_m_wdata <= d_wdata;
              r_m_write <= d_we;
              r_m_read  <= (d_we == 4'd0);
            end else begin
              // A fetch never writes. m_wdata keeps its last value.
              r_m_addr  <= i_addr;
              r_m_write <= 4'd0;
              r_m_read  <= 1'b1;
            end
          end
        end

        ST_ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            // This is the last access cycle, so m_rdata is valid.
            if (r_owner == OWN_FETCH) begin
              r_i_inst <= m_rdata;
              r_i_ack  <= 1'b1;
            end else begin
              // Only loads update d_rdata. A store leaves it untouched.
              if (r_m_read) begin
                r_d_rdata <= m_rdata;
              end
              r_d_ack <= 1'b1;
            end
            r_m_read  <= 1'b0;
            r_m_write <= 4'd0;
            r_state   <= ST_ACK;
          end
        end

        ST_ACK: begin
          // No grant is made here. The acked requester still shows req
          // during this cycle and must not be granted again.
          r_i_ack <= 1'b0;
          r_d_ack <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state   <= ST_IDLE;
          r_m_read  <= 1'b0;
          r_m_write <= 4'd0;
          r_i_ack   <= 1'b0;
          r_d_ack   <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign i_ack   = r_i_ack;
  assign i_inst  = r_i_inst;
  assign d_ack   = r_d_ack;
  assign d_rdata = r_d_rdata;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign m_write = r_m_write;
  assign m_read  = r_m_read;
  assign busy    = r_busy;
  assign owner   = r_owner;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_riscv_mem_arbiter
//
// Purpose:
//   Self-checking bench for riscv_mem_arbiter with two instances.
//   - A WAIT=1 instance runs directed scenarios and then a randomized
//     request mix. Its outputs are compared every cycle against a
//     transaction-level reference model. That model tracks the grant
//     cycle, the access window and the ack cycle with plain arithmetic.
//     It also keeps a word-array image of memory contents.
//   - A WAIT=0 instance runs a single directed load.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_riscv_mem_arbiter;

  localparam int WAIT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- WAIT=1 instance ----------------
  logic        clrn, i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_we;
  logic        i_ack, d_ack, m_read, busy, owner;
  logic [31:0] i_inst, d_rdata, m_addr, m_wdata, m_rdata;
  logic [3:0]  m_write;

  logic [31:0] mem [0:255];
  assign m_rdata = mem[m_addr[9:2]];

  riscv_mem_arbiter #(.WAIT(WAIT), .CW(4)) u_dut (
    .clk(clk), .clrn(clrn),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_inst(i_inst),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_write(m_write), .m_read(m_read),
    .m_rdata(m_rdata), .busy(busy), .owner(owner)
  );

  // ---------------- WAIT=0 instance ----------------
  logic        z_clrn, z_i_req, z_d_req;
  logic [31:0] z_i_addr, z_d_addr, z_d_wdata;
  logic [3:0]  z_d_we;
  logic        z_i_ack, z_d_ack, z_m_read, z_busy, z_owner;
  logic [31:0] z_i_inst, z_d_rdata, z_m_addr, z_m_wdata, z_m_rdata;
  logic [3:0]  z_m_write;

  assign z_m_rdata = (z_m_addr == 32'h0000_0200) ? 32'h1234_5678 : 32'hFFFF_FFFF;

  riscv_mem_arbiter #(.WAIT(0), .CW(4)) u_dut0 (
    .clk(clk), .clrn(z_clrn),
    .i_req(z_i_req), .i_addr(z_i_addr), .i_ack(z_i_ack), .i_inst(z_i_inst),
    .d_req(z_d_req), .d_addr(z_d_addr), .d_we(z_d_we), .d_wdata(z_d_wdata),
    .d_ack(z_d_ack), .d_rdata(z_d_rdata),
    .m_addr(z_m_addr), .m_wdata(z_m_wdata), .m_write(z_m_write), .m_read(z_m_read),
    .m_rdata(z_m_rdata), .busy(z_busy), .owner(z_owner)
  );

  // ---------------- reference model state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [31:0] ref_mem [0:255];

  bit          f_pend, d_pend;                 // outstanding requests
  logic [31:0] f_addr_t, d_addr_t, d_wdata_t;  // true request contents
  logic [3:0]  d_we_t;

  bit          act;                            // access in flight
  bit          a_own;                          // 0 fetch, 1 data
  int          a_k;                            // grant edge number
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_we;
  bit          m_own;
  int          next_free;
  logic [31:0] e_addr, e_inst, e_rdata;

  int          ack_cyc[$];
  bit          ack_who[$];
  int          n_rd, n_wr;

  function automatic logic [31:0] seed(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue_fetch(logic [31:0] a);
    f_pend = 1'b1; f_addr_t = a;
    i_req = 1'b1;  i_addr = a;
  endtask

  task automatic issue_data(logic [31:0] a, logic [3:0] we, logic [31:0] wd);
    d_pend = 1'b1; d_addr_t = a; d_we_t = we; d_wdata_t = wd;
    d_req = 1'b1;  d_addr = a;   d_we = we;   d_wdata = wd;
  endtask

  // Decide what the arbiter must do at the upcoming edge.
  task automatic model_grant();
    int k;
    bit g;
    k = cyc + 1;
    if (!clrn) begin
      act = 1'b0; m_own = 1'b1; e_addr = 32'd0;
      e_inst = 32'd0; e_rdata = 32'd0; next_free = k + 1;
    end else if (!act && k >= next_free && (f_pend || d_pend)) begin
      if (f_pend && d_pend) g = ~m_own;
      else                  g = d_pend;
      act = 1'b1; a_own = g; a_k = k; m_own = g; next_free = k + WAIT + 3;
      if (g) begin
        a_addr = d_addr_t; a_we = d_we_t; a_wdata = d_wdata_t;
        for (int b = 0; b < 4; b++)
          if (a_we[b]) ref_mem[a_addr[9:2]][8*b +: 8] = a_wdata[8*b +: 8];
      end else begin
        a_addr = f_addr_t; a_we = 4'd0; a_wdata = 32'd0;
      end
      e_addr = a_addr;
    end
  endtask

  // Compare every observable output after edge number cyc.
  task automatic check_cycle();
    int n;
    bit s_on, ack_now, bz;
    n = cyc;
    s_on    = act && n >= a_k && n <= a_k + WAIT;
    ack_now = act && n == a_k + WAIT + 1;
    bz      = act && n >= a_k && n <= a_k + WAIT + 1;
    if (ack_now) begin
      if (!a_own)             e_inst  = ref_mem[a_addr[9:2]];
      else if (a_we == 4'd0)  e_rdata = ref_mem[a_addr[9:2]];
    end
    if (m_read === 1'b1)    n_rd++;
    if (m_write !== 4'd0)   n_wr++;
    chk("m_read",  32'(m_read),  32'(s_on && (!a_own || a_we == 4'd0)));
    chk("m_write", 32'(m_write), s_on ? 32'(a_we) : 32'd0);
    chk("m_addr",  m_addr, e_addr);
    if (s_on && a_own && a_we != 4'd0) chk("m_wdata", m_wdata, a_wdata);
    chk("i_ack",   32'(i_ack),   32'(ack_now && !a_own));
    chk("d_ack",   32'(d_ack),   32'(ack_now && a_own));
    chk("i_inst",  i_inst,  e_inst);
    chk("d_rdata", d_rdata, e_rdata);
    chk("busy",    32'(busy),    32'(bz));
    chk("owner",   32'(owner),   32'(m_own));
    chk("ack_excl", 32'(i_ack & d_ack), 32'd0);
    chk("rw_excl",  32'(m_read & (|m_write)), 32'd0);
    if (act && n == a_k) begin
      // The requester may change its inputs once the grant edge has passed.
      if (!a_own) i_addr = $urandom;
      else begin d_addr = $urandom; d_wdata = $urandom; d_we = 4'($urandom); end
    end
    if (ack_now) begin
      ack_cyc.push_back(n);
      ack_who.push_back(a_own);
      $display("txn %0d: cycle %0d %s addr=%h we=%b wdata=%h inst=%h rdata=%h",
               ack_cyc.size(), n, a_own ? "data " : "fetch", a_addr, a_we, a_wdata,
               i_inst, d_rdata);
      if (!a_own) begin f_pend = 1'b0; i_req = 1'b0; end
      else        begin d_pend = 1'b0; d_req = 1'b0; end
      act = 1'b0;
    end
  endtask

  // One clock: model decision, edge, memory write, check on the falling edge.
  task automatic tick();
    logic [3:0]  w_we;
    logic [31:0] w_a, w_d;
    model_grant();
    w_we = m_write; w_a = m_addr; w_d = m_wdata;
    @(posedge clk);
    cyc++;
    if (w_we !== 4'd0 && w_we !== 4'bxxxx)
      for (int b = 0; b < 4; b++)
        if (w_we[b]) mem[w_a[9:2]][8*b +: 8] = w_d[8*b +: 8];
    @(negedge clk);
    check_cycle();
  endtask

  function automatic logic [31:0] rnd_addr();
    return {22'd0, 8'($urandom), 2'b00};
  endfunction

  function automatic logic [3:0] rnd_we();
    return ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sz, bound;
    for (int i = 0; i < 256; i++) begin mem[i] = seed(i); ref_mem[i] = seed(i); end
    mem[4] = 32'h0050_0093; ref_mem[4] = 32'h0050_0093;
    clrn = 1'b0; i_req = 1'b0; d_req = 1'b0;
    i_addr = 32'd0; d_addr = 32'd0; d_we = 4'd0; d_wdata = 32'd0;
    f_pend = 0; d_pend = 0; act = 0; m_own = 1; next_free = 0;
    e_addr = 0; e_inst = 0; e_rdata = 0; a_k = 0; a_own = 0;
    a_addr = 0; a_we = 0; a_wdata = 0; f_addr_t = 0; d_addr_t = 0; d_we_t = 0; d_wdata_t = 0;
    z_clrn = 1'b0; z_i_req = 1'b0; z_d_req = 1'b0;
    z_i_addr = 32'd0; z_d_addr = 32'd0; z_d_we = 4'd0; z_d_wdata = 32'd0;
    @(negedge clk);

    // Reset for two cycles while a fetch request is present.
    issue_fetch(32'h0000_0010);
    repeat (2) tick();
    chk("rst_no_strobe", 32'(m_read | (|m_write)), 32'd0);

    // Single fetch.
    clrn = 1'b1; n_rd = 0;
    repeat (5) tick();
    chk("fetch_txn_count", 32'(ack_cyc.size()), 32'd1);
    chk("fetch_first_owner", 32'(ack_who[0]), 32'd0);
    chk("fetch_ack_edge", 32'(ack_cyc[0]), 32'd5);
    chk("fetch_rd_cycles", 32'(n_rd), 32'd2);
    chk("fetch_inst", i_inst, 32'h0050_0093);

    // Store. The read data register must not change.
    n_rd = 0; n_wr = 0;
    issue_data(32'h0000_0100, 4'b0011, 32'hDEAD_BEEF);
    repeat (5) tick();
    chk("store_wr_cycles", 32'(n_wr), 32'd2);
    chk("store_rd_cycles", 32'(n_rd), 32'd0);
    chk("store_acked", 32'(ack_who[ack_who.size()-1]), 32'd1);
    chk("store_rdata", d_rdata, 32'd0);
    chk("store_mem", 32'(mem[64][15:0]), 32'h0000_BEEF);

    // Both requesters held continuously.
    ack_cyc.delete(); ack_who.delete();
    issue_fetch(rnd_addr());
    issue_data(rnd_addr(), rnd_we(), $urandom);
    repeat (17) begin
      tick();
      if (!f_pend && ack_cyc.size() < 4) issue_fetch(rnd_addr());
      if (!d_pend && ack_cyc.size() < 4) issue_data(rnd_addr(), rnd_we(), $urandom);
    end
    bound = 0;
    while ((f_pend || d_pend) && bound < 40) begin tick(); bound++; end
    chk("rr_drain", 32'(f_pend || d_pend), 32'd0);
    chk("rr_count", 32'(ack_cyc.size() >= 4), 32'd1);
    if (ack_cyc.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("rr_order", 32'(ack_who[i]), 32'(i % 2));
      for (int i = 0; i < 3; i++) chk("rr_spacing", 32'(ack_cyc[i+1] - ack_cyc[i]), 32'd4);
    end

    // Reset on the first ACCESS edge of a store.
    sz = ack_cyc.size();
    issue_data(32'h0000_0180, 4'b1111, 32'hCAFE_F00D);
    tick();
    clrn = 1'b0; d_pend = 1'b0; d_req = 1'b0;
    tick();
    chk("rstmid_m_write", 32'(m_write), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_rdata", d_rdata, 32'd0);
    clrn = 1'b1;
    repeat (4) tick();
    chk("rstmid_no_ack", 32'(ack_cyc.size()), 32'(sz));

    // Randomized request mix.
    repeat (400) begin
      tick();
      if (!f_pend && $urandom_range(0, 2) == 0) issue_fetch(rnd_addr());
      if (!d_pend && $urandom_range(0, 2) == 0) issue_data(rnd_addr(), rnd_we(), $urandom);
    end
    bound = 0;
    while ((f_pend || d_pend) && bound < 40) begin tick(); bound++; end
    chk("rand_drain", 32'(f_pend || d_pend), 32'd0);
    repeat (3) tick();

    // WAIT=0 instance: one load.
    z_clrn = 1'b1; z_d_req = 1'b1; z_d_addr = 32'h0000_0200; z_d_we = 4'd0; z_d_wdata = $urandom;
    @(posedge clk); @(negedge clk);
    chk("w0_read_on", 32'(z_m_read), 32'd1);
    chk("w0_addr", z_m_addr, 32'h0000_0200);
    chk("w0_no_ack_yet", 32'(z_d_ack), 32'd0);
    chk("w0_owner", 32'(z_owner), 32'd1);
    z_d_addr = 32'h0000_0204;
    @(posedge clk); @(negedge clk);
    chk("w0_read_off", 32'(z_m_read), 32'd0);
    chk("w0_ack", 32'(z_d_ack), 32'd1);
    chk("w0_rdata", z_d_rdata, 32'h1234_5678);
    $display("txn w0: load addr=00000200 rdata=%h", z_d_rdata);
    z_d_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("w0_ack_drop", 32'(z_d_ack), 32'd0);
    chk("w0_busy_drop", 32'(z_busy), 32'd0);
    chk("w0_rdata_hold", z_d_rdata, 32'h1234_5678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
